// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
// ---------------------------------------------------------------------------
// Iterative radix-2 Booth multiplier sequencer.
// Signed WIDTH x WIDTH operands give a signed 2*WIDTH product.
// One Booth step is taken per clock, for exactly WIDTH steps.
// The add/subtract itself is done by an external combinational
// adder_subractor. This block drives its i0/i1/cin and consumes its sum
// in the same cycle.
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   in_valid      operand pair valid
//   in_ready      block can accept operands (IDLE only)
//   multiplicand  signed M
//   multiplier    signed Q
//   as_i0         to adder i0, accumulator A
//   as_i1         to adder i1, registered M
//   as_cin        to adder cin, 1 = subtract, 0 = add (only non-zero in RUN)
//   as_sum        from adder sum, combinational in the same cycle
//   out_valid     product valid (DONE)
//   out_ready     consumer accepts product
//   product       {A,Q} in DONE, zero otherwise
//   busy          high in RUN or DONE
//
// Build option
//   BOOTH_ZERO_BYPASS_EN: when defined, a zero multiplicand or multiplier
//   skips the RUN steps. The block goes straight to DONE with a zero product.
// ---------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     as_i0,
    output logic [WIDTH-1:0]     as_i1,
    output logic                 as_cin,
    input  logic [WIDTH-1:0]     as_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;

    logic               do_op;
    logic               ovf;
    logic [WIDTH-1:0]   r;
    logic               s;

`ifdef BOOTH_ZERO_BYPASS_EN
    logic               zero_op;
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`endif

    // The adder always sees the register values. Only cin is gated to RUN,
    // so the adder idles in add mode outside a multiplication.
    assign as_i0  = a_reg;
    assign as_i1  = m_reg;
    assign as_cin = (state == RUN) && q_reg[0] && !q_m1;

    // Booth step result and the shift-in bit.
    // The sign of the shifted accumulator has to be the sign of the true
    // (WIDTH+1)-bit sum. When the adder overflows, its MSB is inverted.
    // This is what makes M = most-negative value come out right.
    always_comb begin
        do_op = q_reg[0] ^ q_m1;
        ovf   = 1'b0;
        r     = a_reg;
        s     = a_reg[WIDTH-1];
        if (do_op) begin
            r = as_sum;
            if (as_cin) begin
                ovf = (a_reg[WIDTH-1] != m_reg[WIDTH-1]) &&
                      (as_sum[WIDTH-1] != a_reg[WIDTH-1]);
            end else begin
                ovf = (a_reg[WIDTH-1] == m_reg[WIDTH-1]) &&
                      (as_sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            s = r[WIDTH-1] ^ ovf;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    // DONE returns to IDLE only through the out_ready handoff. A new operand
    // therefore cannot be taken in the same cycle the product leaves.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        product   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef BOOTH_ZERO_BYPASS_EN
                    state_nxt = zero_op ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                product   = {a_reg, q_reg};
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // Each RUN cycle performs {A,Q,q_m1} <= {s,R,Q}, which is an arithmetic
    // shift right of the step result together with the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
`ifdef BOOTH_ZERO_BYPASS_EN
                        if (zero_op) begin
                            q_reg <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    a_reg <= {s, r[WIDTH-1:1]};
                    q_reg <= {r[0], q_reg[WIDTH-1:1]};
                    q_m1  <= q_reg[0];
                    cnt   <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
